// File: rtl/vreg_access_arbiter_pkg.sv
// Shared types and sizing helpers for the vector register file access arbiter.
package vreg_arb_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Index width for n entries; never narrower than one bit.
    function automatic int reg_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vreg_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid entry at or above ptr, with wrap.
module rr_pick
    import vreg_arb_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IDX_W = reg_w(NREQ)
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_cand
        assign cand[i] = IDX_W'((int'(ptr) + i) % NREQ);
    end

    // Scan from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[cand[i]]) begin
                grant          = '0;
                grant[cand[i]] = 1'b1;
                idx            = cand[i];
            end
        end
    end

endmodule

// File: rtl/vreg_access_arbiter.sv
// Shares the vector register file read/write ports between NREQ requesters,
// one transaction at a time, with round-robin grant and per-requester responses.
module vreg_access_arbiter
    import vreg_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int REG_W   = reg_w(NUM_REGS),
    localparam int IDX_W   = reg_w(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*REG_W-1:0]   req_reg,
    input  logic [NREQ*DATA_W-1:0]  req_wdata,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    rf_we,
    output logic [REG_W-1:0]        rf_wsel,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic [REG_W-1:0]        rf_rsel,
    input  logic [DATA_W-1:0]       rf_rdata
);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic             is_wr;
    logic [NREQ-1:0]  win_grant;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] ptr_next;
    logic             accept;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx)
    );

    // Gated by rst_n so grants vanish the instant reset asserts.
    assign req_ready = (rst_n && state == IDLE) ? win_grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign ptr_next  = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        resp_valid = '0;
        if (state == RESP) resp_valid[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            is_wr      <= 1'b0;
            rf_we      <= 1'b0;
            rf_wsel    <= '0;
            rf_wdata   <= '0;
            rf_rsel    <= '0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner   <= win_idx;
                        is_wr   <= req_we[win_idx];
                        rf_we   <= req_we[win_idx];
                        rf_rsel <= req_reg[win_idx*REG_W +: REG_W];
                        // Write port fields only move on writes so they hold otherwise.
                        if (req_we[win_idx]) begin
                            rf_wsel  <= req_reg[win_idx*REG_W +: REG_W];
                            rf_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
                        end
                        rr_ptr  <= ptr_next;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rf_we <= 1'b0;
                    if (is_wr) begin
                        state <= IDLE;
                    end else begin
                        resp_rdata <= rf_rdata;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[owner]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vreg_access_arbiter.sv
// Directed bench for vreg_access_arbiter with a negedge-writing register file model.
module tb_vreg_access_arbiter;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [1:0]    req_reg;
    logic [127:0]  req_wdata;
    logic [1:0]    resp_valid;
    logic [1:0]    resp_ready;
    logic [63:0]   resp_rdata;
    logic          rf_we;
    logic [0:0]    rf_wsel;
    logic [63:0]   rf_wdata;
    logic [0:0]    rf_rsel;
    logic [63:0]   rf_rdata;

    logic [63:0]   rf_mem [2];

    int n_checks;
    int n_fail;

    localparam logic [63:0] PAT = 64'hDEAD_BEEF_0123_4567;

    vreg_access_arbiter #(.NREQ(2), .DATA_W(64), .NUM_REGS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_reg    (req_reg),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .rf_wdata   (rf_wdata),
        .rf_rsel    (rf_rsel),
        .rf_rdata   (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: writes land on the negedge inside the write cycle.
    always @(negedge clk) if (rf_we) rf_mem[rf_wsel] <= rf_wdata;
    assign rf_rdata = rf_mem[rf_rsel];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One read transaction from grant to response consumption (resp_ready held high).
    task automatic rd_txn(input string tag, input logic [1:0] exp_g, input logic [63:0] exp_d);
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(exp_g));
        tick();
        chk({tag, "_issue_we"}, 64'(rf_we), 64'd0);
        tick();
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(exp_g));
        chk({tag, "_rdata"}, resp_rdata, exp_d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rf_mem[0]  = '0;
        rf_mem[1]  = '0;
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_we     = 2'b00;
        req_reg    = 2'b00;
        req_wdata  = '0;
        resp_ready = 2'b00;

        // Reset state, with requests pending to show grants are suppressed
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_wsel", 64'(rf_wsel), 64'd0);
        chk("rst_rf_wdata", rf_wdata, 64'd0);
        chk("rst_rf_rsel", 64'(rf_rsel), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;

        // Test 1: requester 0 writes PAT to reg 1
        req_valid       = 2'b01;
        req_we          = 2'b01;
        req_reg         = 2'b01;
        req_wdata[63:0] = PAT;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_rf_we", 64'(rf_we), 64'd1);
        chk("t1_rf_wsel", 64'(rf_wsel), 64'd1);
        chk("t1_rf_wdata", rf_wdata, PAT);
        chk("t1_no_ready", 64'(req_ready), 64'd0);
        tick();
        chk("t1_we_drop", 64'(rf_we), 64'd0);
        chk("t1_wsel_hold", 64'(rf_wsel), 64'd1);

        // Test 2: requester 1 reads reg 1, response held off for 5 cycles
        req_valid = 2'b10;
        req_we    = 2'b00;
        req_reg   = 2'b10;
        #1;
        chk("t2_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t2_issue_we", 64'(rf_we), 64'd0);
        chk("t2_rsel", 64'(rf_rsel), 64'd1);
        tick();
        req_valid = 2'b01;
        #1;
        chk("t2_resp_valid", 64'(resp_valid), 64'h2);
        chk("t2_rdata", resp_rdata, PAT);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall_valid", 64'(resp_valid), 64'h2);
            chk("t2_stall_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 2'b01;
        tick();
        chk("t2_nonowner_ignored", 64'(resp_valid), 64'h2);
        resp_ready = 2'b10;
        tick();
        chk("t2_resp_done", 64'(resp_valid), 64'd0);
        chk("t2_idle_ready", 64'(req_ready), 64'h1);
        req_valid = 2'b00;

        // Test 3: both reading continuously, rotation 0,1,0,1
        resp_ready = 2'b11;
        req_we     = 2'b00;
        req_reg    = 2'b10;
        req_valid  = 2'b11;
        rd_txn("t3_a", 2'b01, 64'd0);
        rd_txn("t3_b", 2'b10, PAT);
        rd_txn("t3_c", 2'b01, 64'd0);
        rd_txn("t3_d", 2'b10, PAT);

        // Test 4: after a grant to 0, simultaneous requests favour 1
        req_valid = 2'b01;
        rd_txn("t4_pre", 2'b01, 64'd0);
        req_valid = 2'b11;
        rd_txn("t4_first", 2'b10, PAT);
        rd_txn("t4_second", 2'b01, 64'd0);
        req_valid = 2'b00;

        // Test 5: asynchronous reset during a write issue
        req_valid       = 2'b01;
        req_we          = 2'b01;
        req_reg         = 2'b00;
        req_wdata[63:0] = 64'h55;
        tick();
        chk("t5_rf_we", 64'(rf_we), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_we", 64'(rf_we), 64'd0);
        chk("t5_async_resp", 64'(resp_valid), 64'd0);
        chk("t5_async_ready", 64'(req_ready), 64'd0);
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        #1;
        chk("t5_prio0", 64'(req_ready), 64'h1);
        chk("t5_no_write", rf_mem[0], 64'd0);
        req_valid = 2'b00;

        // Test 6: write reg0=1 then read reg0 from requester 1
        resp_ready      = 2'b00;
        req_valid       = 2'b01;
        req_we          = 2'b01;
        req_reg         = 2'b00;
        req_wdata[63:0] = 64'h1;
        tick();
        req_valid = 2'b10;
        req_we    = 2'b00;
        #1;
        chk("t6_rf_we", 64'(rf_we), 64'd1);
        chk("t6_issue_ready", 64'(req_ready), 64'd0);
        tick();
        chk("t6_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        tick();
        chk("t6_resp_valid", 64'(resp_valid), 64'h2);
        chk("t6_rdata", resp_rdata, 64'h1);
        resp_ready = 2'b10;
        tick();
        chk("t6_resp_done", 64'(resp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
